writeback_unit: RTL and testbench

Writer-side companion to the register file. It collects results from the ALU and load/store unit over valid/ready handshakes, arbitrates between them, and buffers them in a small FIFO. It drives the register file's single write port (rdAddr/rd/rdEnable) and keeps a per-register outstanding-write scoreboard that decode queries for RAW hazards.

---
 rtl/wb_pkg.sv | 17 +
 rtl/wb_fifo.sv | 56 +++++
 rtl/writeback_unit.sv | 124 ++++++++++++
 tb/tb_writeback_unit.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and sizes for the writeback unit
package wb_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int CNT_W      = 2;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSU = 1'b1
    } wb_src_e;
endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - synchronous FIFO with full/empty flags, push and pop on one edge
module wb_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - ALU/LSU result arbiter, writeback queue and RAW scoreboard
module writeback_unit #(
    parameter int XLEN       = wb_pkg::XLEN,
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = wb_pkg::CNT_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         issueValid_In,
    input  logic [wb_pkg::REG_ADDR_W-1:0] issueRd_In,
    output logic                         issueReady_Out,
    input  logic                         aluValid_In,
    input  logic [wb_pkg::REG_ADDR_W-1:0] aluRd_In,
    input  logic [XLEN-1:0]              aluData_In,
    output logic                         aluReady_Out,
    input  logic                         lsuValid_In,
    input  logic [wb_pkg::REG_ADDR_W-1:0] lsuRd_In,
    input  logic [XLEN-1:0]              lsuData_In,
    output logic                         lsuReady_Out,
    input  logic                         wbStall_In,
    output logic [wb_pkg::REG_ADDR_W-1:0] rdAddr_Out,
    output logic [XLEN-1:0]              rd_Out,
    output logic                         rdEnable_Out,
    input  logic [wb_pkg::REG_ADDR_W-1:0] rs1Addr_In,
    input  logic [wb_pkg::REG_ADDR_W-1:0] rs2Addr_In,
    output logic                         rs1Pending_Out,
    output logic                         rs2Pending_Out
);
    import wb_pkg::*;

    localparam int                EW      = REG_ADDR_W + XLEN;
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    wb_src_e               r_rr;
    logic [CNT_W-1:0]      r_cnt [NUM_REGS];
    logic                  w_full;
    logic                  w_empty;
    logic                  w_grant_alu;
    logic                  w_grant_lsu;
    logic                  w_push;
    logic                  w_retire;
    logic                  w_issue_inc;
    logic [REG_ADDR_W-1:0] w_push_rd;
    logic [XLEN-1:0]       w_push_data;
    logic [EW-1:0]         w_head;
    logic [REG_ADDR_W-1:0] w_head_rd;
    logic [XLEN-1:0]       w_head_data;
    logic [NUM_REGS-1:0]   w_inc_vec;
    logic [NUM_REGS-1:0]   w_dec_vec;

    assign w_grant_alu  = aluValid_In && (!lsuValid_In || r_rr == SRC_ALU);
    assign w_grant_lsu  = lsuValid_In && (!aluValid_In || r_rr == SRC_LSU);
    // Readies are forced low during reset because they are otherwise pure combinational.
    assign aluReady_Out = rst && w_grant_alu && !w_full;
    assign lsuReady_Out = rst && w_grant_lsu && !w_full;

    assign w_push_rd   = lsuReady_Out ? lsuRd_In : aluRd_In;
    assign w_push_data = lsuReady_Out ? lsuData_In : aluData_In;
    assign w_push      = (aluReady_Out || lsuReady_Out) && (w_push_rd != '0);

    wb_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_push  (w_push),
        .i_data  ({w_push_rd, w_push_data}),
        .i_pop   (w_retire),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_head_rd    = w_head[EW-1 -: REG_ADDR_W];
    assign w_head_data  = w_head[XLEN-1:0];
    assign w_retire     = !w_empty && !wbStall_In;
    assign rdEnable_Out = w_retire;
    assign rdAddr_Out   = w_retire ? w_head_rd : '0;
    assign rd_Out       = w_retire ? w_head_data : '0;

    assign issueReady_Out = rst && ((issueRd_In == '0) || (r_cnt[issueRd_In] != CNT_MAX));
    assign w_issue_inc    = issueValid_In && issueReady_Out && (issueRd_In != '0);
    assign rs1Pending_Out = (r_cnt[rs1Addr_In] != '0);
    assign rs2Pending_Out = (r_cnt[rs2Addr_In] != '0);

    always_comb begin
        w_inc_vec = '0;
        w_dec_vec = '0;
        if (w_issue_inc) begin
            w_inc_vec[issueRd_In] = 1'b1;
        end
        if (w_retire) begin
            w_dec_vec[w_head_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr <= SRC_ALU;
        end else if (aluReady_Out && lsuValid_In) begin
            r_rr <= SRC_LSU;
        end else if (lsuReady_Out && aluValid_In) begin
            r_rr <= SRC_ALU;
        end
    end

    // x0 never sees an increment (rd!=0 gate) nor a retire (rd=0 never enqueued).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                case ({w_inc_vec[i], w_dec_vec[i]})
                    2'b10: r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                    2'b01: r_cnt[i] <= (r_cnt[i] != '0) ? r_cnt[i] - CNT_W'(1) : r_cnt[i];
                    default: r_cnt[i] <= r_cnt[i];
                endcase
            end
        end
    end
endmodule

// File: tb/tb_writeback_unit.sv
// tb/tb_writeback_unit.sv - directed and random checks of writeback_unit against a queue model
module tb_writeback_unit;
    import wb_pkg::*;

    localparam int DEPTH = 2;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  issueValid_In;
    logic [REG_ADDR_W-1:0] issueRd_In;
    logic                  issueReady_Out;
    logic                  aluValid_In;
    logic [REG_ADDR_W-1:0] aluRd_In;
    logic [XLEN-1:0]       aluData_In;
    logic                  aluReady_Out;
    logic                  lsuValid_In;
    logic [REG_ADDR_W-1:0] lsuRd_In;
    logic [XLEN-1:0]       lsuData_In;
    logic                  lsuReady_Out;
    logic                  wbStall_In;
    logic [REG_ADDR_W-1:0] rdAddr_Out;
    logic [XLEN-1:0]       rd_Out;
    logic                  rdEnable_Out;
    logic [REG_ADDR_W-1:0] rs1Addr_In;
    logic [REG_ADDR_W-1:0] rs2Addr_In;
    logic                  rs1Pending_Out;
    logic                  rs2Pending_Out;

    writeback_unit #(.XLEN(XLEN), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .issueValid_In(issueValid_In), .issueRd_In(issueRd_In), .issueReady_Out(issueReady_Out),
        .aluValid_In(aluValid_In), .aluRd_In(aluRd_In), .aluData_In(aluData_In), .aluReady_Out(aluReady_Out),
        .lsuValid_In(lsuValid_In), .lsuRd_In(lsuRd_In), .lsuData_In(lsuData_In), .lsuReady_Out(lsuReady_Out),
        .wbStall_In(wbStall_In),
        .rdAddr_Out(rdAddr_Out), .rd_Out(rd_Out), .rdEnable_Out(rdEnable_Out),
        .rs1Addr_In(rs1Addr_In), .rs2Addr_In(rs2Addr_In),
        .rs1Pending_Out(rs1Pending_Out), .rs2Pending_Out(rs2Pending_Out)
    );

    always #5 clk = ~clk;

    int      n_checks = 0;
    int      n_fails  = 0;
    wb_entry mq[$];
    int      mcnt[NUM_REGS];
    bit      m_rr_lsu;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        foreach (mcnt[i]) mcnt[i] = 0;
        m_rr_lsu = 1'b0;
    endtask

    task automatic idle();
        issueValid_In = 1'b0; issueRd_In = '0;
        aluValid_In = 1'b0; aluRd_In = '0; aluData_In = '0;
        lsuValid_In = 1'b0; lsuRd_In = '0; lsuData_In = '0;
        wbStall_In = 1'b0; rs1Addr_In = '0; rs2Addr_In = '0;
    endtask

    // Called just after a negedge with inputs already driven; checks, then advances one clock.
    task automatic cycle();
        bit full, ga, gl, ar, lr, en, irdy;
        wb_entry e;
        wb_entry popped;
        #1;
        full = (mq.size() == DEPTH);
        ga   = aluValid_In && (!lsuValid_In || !m_rr_lsu);
        gl   = lsuValid_In && (!aluValid_In || m_rr_lsu);
        ar   = ga && !full;
        lr   = gl && !full;
        en   = (mq.size() != 0) && !wbStall_In;
        irdy = (issueRd_In == 0) || (mcnt[issueRd_In] < MAXC);
        check_eq("aluReady", aluReady_Out, ar);
        check_eq("lsuReady", lsuReady_Out, lr);
        check_eq("rdEnable", rdEnable_Out, en);
        check_eq("rdAddr", rdAddr_Out, en ? mq[0].rd : 0);
        check_eq("rdData", rd_Out, en ? mq[0].data : 0);
        check_eq("issueReady", issueReady_Out, irdy);
        check_eq("rs1Pending", rs1Pending_Out, mcnt[rs1Addr_In] != 0);
        check_eq("rs2Pending", rs2Pending_Out, mcnt[rs2Addr_In] != 0);
        @(posedge clk);
        popped = '0;
        if (en) popped = mq.pop_front();
        if (ar) begin
            if (aluRd_In != 0) begin e.rd = aluRd_In; e.data = aluData_In; mq.push_back(e); end
            if (lsuValid_In) m_rr_lsu = 1'b1;
        end else if (lr) begin
            if (lsuRd_In != 0) begin e.rd = lsuRd_In; e.data = lsuData_In; mq.push_back(e); end
            if (aluValid_In) m_rr_lsu = 1'b0;
        end
        if (issueValid_In && irdy && issueRd_In != 0) mcnt[issueRd_In]++;
        if (en && mcnt[popped.rd] > 0) mcnt[popped.rd]--;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    initial begin
        rst = 1'b0;
        idle();
        aluValid_In = 1'b1; lsuValid_In = 1'b1; issueValid_In = 1'b1; issueRd_In = 5'd3;
        #12;
        check_eq("rst_aluReady", aluReady_Out, 0);
        check_eq("rst_lsuReady", lsuReady_Out, 0);
        check_eq("rst_issueReady", issueReady_Out, 0);
        check_eq("rst_rdEnable", rdEnable_Out, 0);
        check_eq("rst_rdAddr", rdAddr_Out, 0);
        check_eq("rst_rdData", rd_Out, 0);
        check_eq("rst_pending", {rs1Pending_Out, rs2Pending_Out}, 0);
        @(negedge clk);
        idle();
        rst = 1'b1;
        model_reset();

        // Issue, result, retire, pending clears.
        issueValid_In = 1'b1; issueRd_In = 5'd5; rs1Addr_In = 5'd5;
        #1 check_eq("t1_issueReady", issueReady_Out, 1);
        cycle();
        issueValid_In = 1'b0; aluValid_In = 1'b1; aluRd_In = 5'd5; aluData_In = 32'hDEADBEEF;
        #1 check_eq("t1_pend", rs1Pending_Out, 1);
        cycle();
        aluValid_In = 1'b0;
        #1 check_eq("t1_wr", {rdEnable_Out, rdAddr_Out, rd_Out}, {1'b1, 5'd5, 32'hDEADBEEF});
        cycle();
        #1 check_eq("t1_pend_clr", rs1Pending_Out, 0);
        cycle();

        // Contested arbitration after reset.
        do_reset();
        aluValid_In = 1'b1; aluRd_In = 5'd3; aluData_In = 32'h11;
        lsuValid_In = 1'b1; lsuRd_In = 5'd4; lsuData_In = 32'h22;
        #1 check_eq("t2_first", {aluReady_Out, lsuReady_Out}, 2'b10);
        cycle();
        aluValid_In = 1'b0;
        #1 check_eq("t2_second", {lsuReady_Out, rdEnable_Out, rdAddr_Out}, {1'b1, 1'b1, 5'd3});
        cycle();
        lsuValid_In = 1'b0;
        #1 check_eq("t2_wr4", {rdEnable_Out, rdAddr_Out, rd_Out}, {1'b1, 5'd4, 32'h22});
        cycle();

        // Stall fills the queue; third result back-pressured.
        wbStall_In = 1'b1; aluValid_In = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            aluRd_In = (k < 3) ? 5'(k) : 5'd3; aluData_In = 32'(k * 100);
            #1 check_eq("t3_stall_en", rdEnable_Out, 0);
            if (k >= 3) check_eq("t3_full_ready", aluReady_Out, 0);
            cycle();
        end
        wbStall_In = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            if (k == 3) aluValid_In = 1'b0;
            #1 check_eq("t3_order", {rdEnable_Out, rdAddr_Out}, {1'b1, 5'(k)});
            cycle();
        end

        // rd=0 result is accepted but dropped.
        rs1Addr_In = 5'd0; rs2Addr_In = 5'd5;
        lsuValid_In = 1'b1; lsuRd_In = 5'd0; lsuData_In = 32'h55;
        #1 check_eq("t4_ready", lsuReady_Out, 1);
        cycle();
        lsuValid_In = 1'b0;
        #1 check_eq("t4_noWrite", {rdEnable_Out, rs1Pending_Out, rs2Pending_Out}, 3'b000);
        cycle();

        // Counter saturation and same-cycle inc/dec.
        issueValid_In = 1'b1; issueRd_In = 5'd7; rs1Addr_In = 5'd7;
        repeat (3) cycle();
        #1 check_eq("t5_sat", issueReady_Out, 0);
        cycle();
        issueValid_In = 1'b0; aluValid_In = 1'b1; aluRd_In = 5'd7; aluData_In = 32'h77;
        cycle();
        issueValid_In = 1'b1;
        #1 check_eq("t5_sat_retire", {issueReady_Out, rdEnable_Out}, 2'b01);
        cycle();
        aluValid_In = 1'b0;
        #1 check_eq("t5_incdec", {issueReady_Out, rdEnable_Out, rdAddr_Out}, {2'b11, 5'd7});
        cycle();
        cycle();
        #1 check_eq("t5_held2", issueReady_Out, 0);
        cycle();

        // Reset mid-cycle with two queued entries.
        do_reset();
        wbStall_In = 1'b1; issueValid_In = 1'b1; aluValid_In = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            issueRd_In = 5'(k); aluRd_In = 5'(k); aluData_In = 32'(k);
            cycle();
        end
        wbStall_In = 1'b0; issueRd_In = 5'd3; aluRd_In = 5'd9;
        rs1Addr_In = 5'd1; rs2Addr_In = 5'd2;
        #1 check_eq("t6_pre", {rdEnable_Out, rs1Pending_Out, rs2Pending_Out}, 3'b111);
        #2 rst = 1'b0;
        #1;
        check_eq("t6_async_en", rdEnable_Out, 0);
        check_eq("t6_async_rdy", {aluReady_Out, lsuReady_Out, issueReady_Out}, 0);
        check_eq("t6_async_pend", {rs1Pending_Out, rs2Pending_Out}, 0);
        check_eq("t6_async_addr", rdAddr_Out, 0);
        idle();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        repeat (3) begin
            #1 check_eq("t6_nowrite", rdEnable_Out, 0);
            cycle();
        end

        // Random traffic against the model.
        for (int n = 0; n < 500; n++) begin
            issueValid_In = 1'($urandom_range(0, 1));
            issueRd_In    = 5'($urandom_range(0, 7));
            aluValid_In   = 1'($urandom_range(0, 1));
            aluRd_In      = 5'($urandom_range(0, 7));
            aluData_In    = $urandom;
            lsuValid_In   = 1'($urandom_range(0, 1));
            lsuRd_In      = 5'($urandom_range(0, 7));
            lsuData_In    = $urandom;
            wbStall_In    = ($urandom_range(0, 3) == 0);
            rs1Addr_In    = 5'($urandom_range(0, 7));
            rs2Addr_In    = 5'($urandom_range(0, 7));
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
